regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Parameters
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = no forwarding.

Interface
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port A1  input  ADDR_W  read port 1 address.
REQ-007 SHALL have port A2  input  ADDR_W  read port 2 address.
REQ-008 SHALL have port A3  input  ADDR_W  write address.
REQ-009 SHALL have port WD3  input  DATA_W  write data.
REQ-010 SHALL have port RegWrite  input  1  write enable, qualifies A3/WD3.
REQ-011 SHALL have port ISSUE_EN  input  1  marks ISSUE_RD as a pending destination.
REQ-012 SHALL have port ISSUE_RD  input  ADDR_W  destination register of the issuing instruction.
REQ-013 SHALL have port RD1  output  DATA_W  read port 1 data.
REQ-014 SHALL have port RD2  output  DATA_W  read port 2 data.
REQ-015 SHALL have port BUSY1  output  1  register at A1 has an outstanding write.
REQ-016 SHALL have port BUSY2  output  1  register at A2 has an outstanding write.

Function
REQ-017 Storage SHALL be 2**ADDR_W registers of DATA_W bits, written only on the rising CLK edge when RegWrite=1 and A3!=0.
REQ-018 Register 0 SHALL read as zero always; writes and issues to register 0 SHALL be ignored.
REQ-019 RD1/RD2 SHALL be combinational reads of the stored value at A1/A2 (zero-latency read).
REQ-020 With BYPASS=1, when RegWrite=1, A3!=0 and A3==A1 (resp. A2), RD1 (resp. RD2) SHALL equal WD3 in the same cycle.
REQ-021 With BYPASS=0, a read of the register being written SHALL return the old value until the next cycle.
REQ-022 Scoreboard SHALL hold one busy bit per register; bit 0 constantly 0.
REQ-023 On a rising edge with ISSUE_EN=1 and ISSUE_RD!=0, busy[ISSUE_RD] SHALL be set.
REQ-024 On a rising edge with RegWrite=1 and A3!=0, busy[A3] SHALL be cleared.
REQ-025 Simultaneous issue and write to the same register SHALL leave busy set (issue wins; data still written).
REQ-026 Issue to an already-busy register SHALL leave it busy (no counting; one outstanding writer per register).
REQ-027 BUSY1 SHALL be busy[A1], except with BYPASS=1 it SHALL be 0 when the same-cycle write targets A1; BUSY2 likewise for A2.
REQ-028 A1==A2 SHALL return identical RD and BUSY values on both ports.

Reset
REQ-029 RST_N=0 SHALL asynchronously clear all registers and all busy bits to 0, independent of CLK.
REQ-030 During reset RD1/RD2 SHALL read 0 and BUSY1/BUSY2 SHALL be 0; writes and issues SHALL be ignored.
REQ-031 Reset asserted mid-operation SHALL discard any write or issue presented in that cycle; first update is the first rising edge after RST_N rises.

Verification
REQ-032 Reset then A1=7,A2=31 -> RD1=0, RD2=0, BUSY1=0, BUSY2=0.
REQ-033 Write A3=5, WD3=0xDEADBEEF, RegWrite=1, A1=5 (BYPASS=1) -> RD1=0xDEADBEEF in the same cycle; with BYPASS=0 -> RD1=0 that cycle, 0xDEADBEEF next cycle.
REQ-034 Write A3=0, WD3=0x12345678 -> A1=0 reads 0; ISSUE_RD=0 -> BUSY1=0 for A1=0.
REQ-035 ISSUE_EN=1, ISSUE_RD=9 at edge N; A2=9 -> BUSY2=1 from N; RegWrite A3=9 at edge N+3 -> BUSY2=0 after N+3 (0 during that cycle with BYPASS=1).
REQ-036 Same edge ISSUE_RD=12 and RegWrite A3=12, WD3=0x55 -> register 12 = 0x55, busy[12]=1.
REQ-037 Registers 3=0xA5A5A5A5 and busy[3]=1, assert RST_N=0 between edges -> RD for A1=3 is 0 and BUSY1=0 immediately, without a CLK edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with per-register busy scoreboard
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              RegWrite,
  input  logic              ISSUE_EN,
  input  logic [ADDR_W-1:0] ISSUE_RD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY1,
  output logic              BUSY2
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  set_v;
  logic [DEPTH-1:0]  clr_v;
  logic              wr_en;
  logic              fwd1;
  logic              fwd2;
  // Register 0 is never a legal target, so masking it here keeps regs[0] and busy[0] at zero forever.
  // Forwarding is gated by RST_N so reads stay zero while reset is held.
  always_comb begin
    wr_en = RegWrite && (A3 != '0);
    set_v = (ISSUE_EN && (ISSUE_RD != '0)) ? (DEPTH'(1) << ISSUE_RD) : '0;
    clr_v = wr_en ? (DEPTH'(1) << A3) : '0;
    fwd1  = (BYPASS != 0) && RST_N && wr_en && (A3 == A1);
    fwd2  = (BYPASS != 0) && RST_N && wr_en && (A3 == A2);
    RD1   = fwd1 ? WD3 : regs[A1];
    RD2   = fwd2 ? WD3 : regs[A2];
    BUSY1 = fwd1 ? 1'b0 : busy[A1];
    BUSY2 = fwd2 ? 1'b0 : busy[A2];
  end
  // Register storage: async clear, write on qualified RegWrite.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end
  end
  // Scoreboard: a completing write clears its bit, a same-edge issue re-sets it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) busy <= '0;
    else        busy <= (busy & ~clr_v) | set_v;
  end
endmodule
